// File: rtl/spl_host_responder.sv
// spl_host_responder
//   Host-side stand-in for the SPL end of the AFU/SPL request-response link.
//   AFU read requests are queued in a read FIFO and answered from an internal
//   cache-line memory. Write and interrupt requests share a second FIFO so
//   their relative order is kept. Writes update the memory and are acked on
//   channel 1. Interrupts are acked on channel 1 without touching memory.
//
//   After reset_n is released the responder waits HOLD_CYCLES clocks before
//   it starts popping either FIFO. Requests made during this warm-up window
//   are queued. The AFU therefore sees a backlog right after reset, and the
//   almostfull and overflow paths can be exercised.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   afu_tx_rd_valid / afu_tx_rd_hdr    read request; hdr[13:0] mdata,
//                                      hdr[14+MEM_ADDR_WIDTH-1:14] line
//   spl_tx_rd_almostfull               read FIFO occupancy >= AF_THRESH
//   afu_tx_wr_valid / afu_tx_intr_valid write and interrupt strobes
//   afu_tx_wr_hdr / afu_tx_data        write/interrupt header, write data
//   spl_tx_wr_almostfull               write FIFO occupancy >= AF_THRESH
//   spl_rx_rd_valid / hdr0 / data      channel-0 read response
//   spl_rx_wr_valid1 / intr_valid1     channel-1 write / interrupt ack
//   spl_rx_hdr1                        channel-1 header
//   err_overflow                       sticky: push dropped at a full FIFO
//   err_protocol                       sticky: write and interrupt in one cycle

// Request FIFO with occupancy-based, registered almostfull.
module spl_req_fifo #(
  parameter int WIDTH     = 20,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pop,
  output logic             overflow,
  output logic             almostfull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             almostfull_r;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == FULL_CNT);
  assign pop_s     = pop_en & ~empty_s;
  // A push at full still succeeds when a pop frees a slot in the same cycle.
  assign push_ok_s = push & (~full_s | pop_s);
  assign overflow  = push & full_s & ~pop_s;
  assign pop       = pop_s;
  assign dout      = store_r[rd_ptr_r];
  assign almostfull = almostfull_r;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_ok_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_ok_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy and almostfull registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      almostfull_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r      <= count_nxt_s;
      almostfull_r <= (count_nxt_s >= AF_CNT);
    end
  end

  // Entry storage. The pointers define validity, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) store_r[wr_ptr_r] <= din;
  end

endmodule

// Top level: two request FIFOs, line memory and registered responses.
module spl_host_responder #(
  parameter int TXHDR_WIDTH    = 99,
  parameter int RXHDR_WIDTH    = 24,
  parameter int CACHE_WIDTH    = 512,
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH     = 8,
  parameter int AF_THRESH      = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   afu_tx_rd_valid,
  input  logic [TXHDR_WIDTH-1:0] afu_tx_rd_hdr,
  output logic                   spl_tx_rd_almostfull,
  input  logic                   afu_tx_wr_valid,
  input  logic                   afu_tx_intr_valid,
  input  logic [TXHDR_WIDTH-1:0] afu_tx_wr_hdr,
  input  logic [CACHE_WIDTH-1:0] afu_tx_data,
  output logic                   spl_tx_wr_almostfull,
  output logic                   spl_rx_rd_valid,
  output logic [RXHDR_WIDTH-1:0] spl_rx_hdr0,
  output logic [CACHE_WIDTH-1:0] spl_rx_data,
  output logic                   spl_rx_wr_valid1,
  output logic                   spl_rx_intr_valid1,
  output logic [RXHDR_WIDTH-1:0] spl_rx_hdr1,
  output logic                   err_overflow,
  output logic                   err_protocol
);

  localparam int MW      = MEM_ADDR_WIDTH;
  localparam int MD_W    = 14;
  localparam int RD_W    = MD_W + MW;
  localparam int WR_W    = 1 + RD_W + CACHE_WIDTH;
  localparam int LINES   = 1 << MW;
  localparam logic [3:0] HOLD_LAST = 4'd12;

  // Header bits above the line address are ignored, so addresses wrap.
  logic unused_hdr_bits_s;
  assign unused_hdr_bits_s = ^{afu_tx_rd_hdr[TXHDR_WIDTH-1:RD_W],
                               afu_tx_wr_hdr[TXHDR_WIDTH-1:RD_W]};

  logic [CACHE_WIDTH-1:0] line_mem_r [LINES];

  logic [3:0]      hold_cnt_r;
  logic            hold_done_s;

  logic [RD_W-1:0] rd_dout_s;
  logic            rd_pop_s;
  logic            rd_ovf_s;
  logic            rd_af_s;
  logic [MW-1:0]   rd_addr_s;
  logic [MD_W-1:0] rd_mdata_s;

  logic [WR_W-1:0] wr_din_s;
  logic [WR_W-1:0] wr_dout_s;
  logic            wr_push_s;
  logic            wr_pop_s;
  logic            wr_ovf_s;
  logic            wr_af_s;
  logic            wr_kind_s;
  logic [MW-1:0]   wr_addr_s;
  logic [MD_W-1:0] wr_mdata_s;
  logic [CACHE_WIDTH-1:0] wr_data_s;

  logic                   rd_valid_r;
  logic [RXHDR_WIDTH-1:0] hdr0_r;
  logic [CACHE_WIDTH-1:0] data_r;
  logic                   wr_valid1_r;
  logic                   intr_valid1_r;
  logic [RXHDR_WIDTH-1:0] hdr1_r;
  logic                   err_overflow_r;
  logic                   err_protocol_r;

  assign hold_done_s = (hold_cnt_r == HOLD_LAST);

  // Post-reset warm-up counter; pops stay disabled until it saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r <= 4'd0;
    end else if (!hold_done_s) begin
      hold_cnt_r <= hold_cnt_r + 4'd1;
    end
  end

  spl_req_fifo #(
    .WIDTH     (RD_W),
    .DEPTH     (FIFO_DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_rd_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (afu_tx_rd_valid),
    .pop_en     (hold_done_s),
    .din        (afu_tx_rd_hdr[RD_W-1:0]),
    .dout       (rd_dout_s),
    .pop        (rd_pop_s),
    .overflow   (rd_ovf_s),
    .almostfull (rd_af_s)
  );

  assign rd_addr_s  = rd_dout_s[RD_W-1:MD_W];
  assign rd_mdata_s = rd_dout_s[MD_W-1:0];

  // A simultaneous write and interrupt keeps only the write (kind bit 0).
  assign wr_push_s = afu_tx_wr_valid | afu_tx_intr_valid;
  assign wr_din_s  = {afu_tx_intr_valid & ~afu_tx_wr_valid,
                      afu_tx_wr_hdr[RD_W-1:0], afu_tx_data};

  spl_req_fifo #(
    .WIDTH     (WR_W),
    .DEPTH     (FIFO_DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_wr_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (wr_push_s),
    .pop_en     (hold_done_s),
    .din        (wr_din_s),
    .dout       (wr_dout_s),
    .pop        (wr_pop_s),
    .overflow   (wr_ovf_s),
    .almostfull (wr_af_s)
  );

  assign wr_kind_s  = wr_dout_s[WR_W-1];
  assign wr_addr_s  = wr_dout_s[WR_W-2 -: MW];
  assign wr_mdata_s = wr_dout_s[CACHE_WIDTH+MD_W-1:CACHE_WIDTH];
  assign wr_data_s  = wr_dout_s[CACHE_WIDTH-1:0];

  // Line memory. A read popped in the same cycle as a write to the same line
  // samples the array before this update lands, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (wr_pop_s && !wr_kind_s) line_mem_r[wr_addr_s] <= wr_data_s;
  end

  // Registered responses and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r     <= 1'b0;
      hdr0_r         <= {RXHDR_WIDTH{1'b0}};
      data_r         <= {CACHE_WIDTH{1'b0}};
      wr_valid1_r    <= 1'b0;
      intr_valid1_r  <= 1'b0;
      hdr1_r         <= {RXHDR_WIDTH{1'b0}};
      err_overflow_r <= 1'b0;
      err_protocol_r <= 1'b0;
    end else begin
      rd_valid_r    <= rd_pop_s;
      wr_valid1_r   <= wr_pop_s & ~wr_kind_s;
      intr_valid1_r <= wr_pop_s & wr_kind_s;
      if (rd_pop_s) begin
        hdr0_r <= RXHDR_WIDTH'({4'h4, 6'h00, rd_mdata_s});
        data_r <= line_mem_r[rd_addr_s];
      end
      if (wr_pop_s) begin
        hdr1_r <= RXHDR_WIDTH'({(wr_kind_s ? 4'h8 : 4'h1), 6'h00, wr_mdata_s});
      end
      err_overflow_r <= err_overflow_r | rd_ovf_s | wr_ovf_s;
      err_protocol_r <= err_protocol_r | (afu_tx_wr_valid & afu_tx_intr_valid);
    end
  end

  assign spl_tx_rd_almostfull = rd_af_s;
  assign spl_tx_wr_almostfull = wr_af_s;
  assign spl_rx_rd_valid      = rd_valid_r;
  assign spl_rx_hdr0          = hdr0_r;
  assign spl_rx_data          = data_r;
  assign spl_rx_wr_valid1     = wr_valid1_r;
  assign spl_rx_intr_valid1   = intr_valid1_r;
  assign spl_rx_hdr1          = hdr1_r;
  assign err_overflow         = err_overflow_r;
  assign err_protocol         = err_protocol_r;

endmodule

// File: tb/tb_spl_host_responder.sv
// Directed testbench for spl_host_responder. Inputs are driven and outputs
// are sampled 1 ns after each rising clock edge.
module tb_spl_host_responder;

  logic         clk;
  logic         reset_n;
  logic         rd_valid;
  logic [98:0]  rd_hdr;
  logic         rd_af;
  logic         wr_valid;
  logic         intr_valid;
  logic [98:0]  wr_hdr;
  logic [511:0] tx_data;
  logic         wr_af;
  logic         rx_rd_valid;
  logic [23:0]  rx_hdr0;
  logic [511:0] rx_data;
  logic         rx_wr_valid1;
  logic         rx_intr_valid1;
  logic [23:0]  rx_hdr1;
  logic         err_ovf;
  logic         err_prot;

  int n_vec;
  int n_err;

  spl_host_responder dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .afu_tx_rd_valid      (rd_valid),
    .afu_tx_rd_hdr        (rd_hdr),
    .spl_tx_rd_almostfull (rd_af),
    .afu_tx_wr_valid      (wr_valid),
    .afu_tx_intr_valid    (intr_valid),
    .afu_tx_wr_hdr        (wr_hdr),
    .afu_tx_data          (tx_data),
    .spl_tx_wr_almostfull (wr_af),
    .spl_rx_rd_valid      (rx_rd_valid),
    .spl_rx_hdr0          (rx_hdr0),
    .spl_rx_data          (rx_data),
    .spl_rx_wr_valid1     (rx_wr_valid1),
    .spl_rx_intr_valid1   (rx_intr_valid1),
    .spl_rx_hdr1          (rx_hdr1),
    .err_overflow         (err_ovf),
    .err_protocol         (err_prot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [98:0] mk_hdr(input logic [6:0] line, input logic [13:0] md);
    logic [98:0] h;
    h = '0;
    h[13:0]  = md;
    h[20:14] = line;
    return h;
  endfunction

  task automatic idle_inputs();
    rd_valid   = 1'b0;
    wr_valid   = 1'b0;
    intr_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"},  rx_rd_valid,    1'b0);
    check({tag, "_hdr0"},      rx_hdr0,        24'h0);
    check({tag, "_data"},      rx_data,        512'h0);
    check({tag, "_wr_valid1"}, rx_wr_valid1,   1'b0);
    check({tag, "_intr1"},     rx_intr_valid1, 1'b0);
    check({tag, "_hdr1"},      rx_hdr1,        24'h0);
    check({tag, "_rd_af"},     rd_af,          1'b0);
    check({tag, "_wr_af"},     wr_af,          1'b0);
    check({tag, "_err_ovf"},   err_ovf,        1'b0);
    check({tag, "_err_prot"},  err_prot,       1'b0);
  endtask

  initial begin
    int cnt;
    int idx;
    logic [98:0] h;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b1;
    idle_inputs();
    rd_hdr  = '0;
    wr_hdr  = '0;
    tx_data = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Write line 5, then read it back
    wr_valid = 1'b1;
    wr_hdr   = mk_hdr(7'd5, 14'h0012);
    tx_data  = {64{8'hA5}};
    tick();
    idle_inputs();
    tick();
    check("wr_ack", rx_wr_valid1, 1'b1);
    check("wr_ack_hdr1", rx_hdr1, 24'h100012);
    check("wr_ack_no_intr", rx_intr_valid1, 1'b0);
    tick();
    check("wr_ack_pulse", rx_wr_valid1, 1'b0);
    rd_valid = 1'b1;
    rd_hdr   = mk_hdr(7'd5, 14'h0033);
    tick();
    idle_inputs();
    check("rd_not_early", rx_rd_valid, 1'b0);
    tick();
    check("rd_valid", rx_rd_valid, 1'b1);
    check("rd_hdr0", rx_hdr0, 24'h400033);
    check("rd_data", rx_data, {64{8'hA5}});
    tick();
    check("rd_pulse", rx_rd_valid, 1'b0);

    // Preload lines 0..7 with their index
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_hdr   = mk_hdr(7'(i), 14'(16'h0100 + i));
      tx_data  = 512'(i);
      tick();
      if (rx_wr_valid1) cnt++;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rx_wr_valid1) cnt++;
    end
    check("preload_acks", 32'(cnt), 32'd8);

    // 8 back-to-back reads: back-to-back in-order responses, no almostfull
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        rd_valid = 1'b1;
        rd_hdr   = mk_hdr(7'(c), 14'(c));
      end else begin
        rd_valid = 1'b0;
      end
      tick();
      check("b2b_valid", rx_rd_valid, (c >= 1 && c <= 8) ? 1'b1 : 1'b0);
      if (c >= 1 && c <= 8) begin
        check("b2b_hdr0", rx_hdr0, {4'h4, 6'h00, 14'(c - 1)});
        check("b2b_data", rx_data, 512'(c - 1));
      end
      check("b2b_no_af", rd_af, 1'b0);
    end

    // Overflow: fill the read FIFO during the post-reset warm-up
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      rd_valid = 1'b1;
      rd_hdr   = mk_hdr(7'(c % 8), 14'(16'h0200 + c));
      tick();
      check("fill_no_rsp", rx_rd_valid, 1'b0);
      if (c == 4) check("af_below", rd_af, 1'b0);
      if (c == 5) check("af_at_thresh", rd_af, 1'b1);
      if (c == 7) check("ovf_not_yet", err_ovf, 1'b0);
      if (c == 8) check("ovf_set", err_ovf, 1'b1);
    end
    idle_inputs();
    idx = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (rx_rd_valid) begin
        check("drain_hdr0", rx_hdr0, {4'h4, 6'h00, 14'(16'h0200 + idx)});
        check("drain_data", rx_data, 512'(idx));
        idx++;
      end
    end
    check("drain_count", 32'(idx), 32'd8);
    check("drain_af_low", rd_af, 1'b0);
    check("ovf_sticky", err_ovf, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Write then interrupt on consecutive cycles
    wr_valid = 1'b1;
    wr_hdr   = mk_hdr(7'd9, 14'h0001);
    tx_data  = 512'h1234;
    tick();
    wr_valid   = 1'b0;
    intr_valid = 1'b1;
    wr_hdr     = mk_hdr(7'd0, 14'h0007);
    tick();
    idle_inputs();
    check("seq_wr_ack", rx_wr_valid1, 1'b1);
    check("seq_wr_no_intr", rx_intr_valid1, 1'b0);
    check("seq_wr_hdr1", rx_hdr1, 24'h100001);
    tick();
    check("seq_intr_ack", rx_intr_valid1, 1'b1);
    check("seq_intr_no_wr", rx_wr_valid1, 1'b0);
    check("seq_intr_hdr1", rx_hdr1, 24'h800007);
    tick();
    check("seq_intr_pulse", rx_intr_valid1, 1'b0);
    check("prot_clear", err_prot, 1'b0);

    // Same-cycle write and interrupt
    wr_valid   = 1'b1;
    intr_valid = 1'b1;
    wr_hdr     = mk_hdr(7'd10, 14'h0015);
    tx_data    = 512'h55;
    tick();
    idle_inputs();
    check("prot_set", err_prot, 1'b1);
    tick();
    check("both_wr_ack", rx_wr_valid1, 1'b1);
    check("both_hdr1", rx_hdr1, 24'h100015);
    check("both_no_intr", rx_intr_valid1, 1'b0);
    tick();
    check("both_no_intr2", rx_intr_valid1, 1'b0);
    check("both_no_wr2", rx_wr_valid1, 1'b0);

    // Read-before-write on line 3, then an aliased read
    wr_valid = 1'b1;
    wr_hdr   = mk_hdr(7'd3, 14'h0030);
    tx_data  = 512'd1;
    tick();
    idle_inputs();
    tick();
    tick();
    rd_valid = 1'b1;
    rd_hdr   = mk_hdr(7'd3, 14'h0031);
    wr_valid = 1'b1;
    wr_hdr   = mk_hdr(7'd3, 14'h0032);
    tx_data  = 512'd2;
    tick();
    idle_inputs();
    tick();
    check("rbw_valid", rx_rd_valid, 1'b1);
    check("rbw_old_data", rx_data, 512'd1);
    check("rbw_wr_ack", rx_wr_valid1, 1'b1);
    check("rbw_wr_hdr1", rx_hdr1, 24'h100032);
    h = mk_hdr(7'd3, 14'h0034);
    h[20] = 1'b1;
    rd_valid = 1'b1;
    rd_hdr   = h;
    tick();
    idle_inputs();
    tick();
    check("alias_valid", rx_rd_valid, 1'b1);
    check("alias_hdr0", rx_hdr0, 24'h400034);
    check("alias_new_data", rx_data, 512'd2);
    tick();

    // Reset with reads in flight
    for (int c = 0; c < 3; c++) begin
      rd_valid = 1'b1;
      rd_hdr   = mk_hdr(7'(c), 14'(16'h0300 + c));
      tick();
    end
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (rx_rd_valid) cnt++;
    end
    check("midrst_no_rsp", 32'(cnt), 32'd0);
    check("midrst_af", rd_af, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
